// File: rtl/audio_ns_ctrl.sv
// audio_ns_ctrl: sequencer that feeds mono samples to one fix_audio_ns core.
// Samples come in on a valid/ready stream and go to the core over a toggle
// req/ack handshake. Results go out on a valid/ready stream. Conf changes are
// applied by holding core_enable low for a fixed time, and only between samples.
module audio_ns_ctrl #(
    parameter  int FIXWID  = 16,
    parameter  int DIS_CYC = 20,
    parameter  int TMO_CYC = 4096,
    localparam int CW      = 3*FIXWID+4
) (
    input  logic              clk,
    input  logic              rst,

    // sample input stream
    input  logic              in_valid,
    input  logic [FIXWID-1:0] in_data,
    output logic              in_ready,

    // result output stream
    output logic              out_valid,
    output logic [FIXWID-1:0] out_data,
    input  logic              out_ready,

    // configuration port
    input  logic              cfg_wr,
    input  logic [CW-1:0]     cfg_data,
    output logic              cfg_busy,

    // core side
    output logic [CW-1:0]     core_conf,
    output logic              core_enable,
    output logic              core_req,
    output logic [FIXWID-1:0] core_rx_data,
    input  logic              core_ack,
    input  logic [FIXWID-1:0] core_tx_data,
    input  logic              core_overflow,

    // error reporting
    output logic              tmo_err,
    output logic [7:0]        ovf_cnt,
    input  logic              err_clr
);

    localparam int DIS_W = $clog2(DIS_CYC + 1);
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    localparam logic [DIS_W-1:0] DIS_LAST = DIS_W'(DIS_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    typedef enum logic [1:0] {
        ST_DIS   = 2'd0,
        ST_READY = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [DIS_W-1:0]  dis_cnt;
    logic [DIS_W-1:0]  dis_cnt_now;
    logic [TMO_W-1:0]  tmo_cnt;

    logic [CW-1:0]     pend_conf;
    logic              pend;
    logic              ack_q;

    logic              accept;
    logic              done;
    logic              timeout;
    logic              enter_dis;
    logic              dis_load;
    logic              dis_exit;
    logic              conf_load;
    logic              ovf_inc;

    // Next-state decode plus the one-cycle strobes that steer the datapath.
    // In DIS, a fresh conf (new write or one left pending) restarts the
    // disable period; the loading cycle itself counts as the first low cycle.
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        done        = 1'b0;
        timeout     = 1'b0;
        enter_dis   = 1'b0;
        dis_load    = 1'b0;
        dis_exit    = 1'b0;
        dis_cnt_now = dis_cnt;
        in_ready    = 1'b0;

        unique case (state)
            ST_DIS: begin
                dis_load    = cfg_wr || pend;
                dis_cnt_now = dis_load ? '0 : dis_cnt;
                if (dis_cnt_now == DIS_LAST) begin
                    dis_exit  = 1'b1;
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                in_ready = !pend && !out_valid;
                if (in_valid && !pend && !out_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_BUSY;
                end else if (pend && !out_valid) begin
                    enter_dis = 1'b1;
                    state_nxt = ST_DIS;
                end
            end
            ST_BUSY: begin
                if (core_ack != ack_q) begin
                    done      = 1'b1;
                    state_nxt = ST_READY;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout   = 1'b1;
                    enter_dis = 1'b1;
                    state_nxt = ST_DIS;
                end
            end
            default: begin
                state_nxt = ST_DIS;
            end
        endcase
    end

    assign conf_load = enter_dis || dis_load;
    assign ovf_inc   = done && core_overflow;
    assign cfg_busy  = pend || (state == ST_DIS);

    // State register; reset lands in DIS so the core starts disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_DIS;
        end else begin
            state <= state_nxt;
        end
    end

    // Disable-period counter: cleared on entry, advanced through DIS.
    always_ff @(posedge clk) begin
        if (rst) begin
            dis_cnt <= '0;
        end else if (enter_dis) begin
            dis_cnt <= '0;
        end else if ((state == ST_DIS) && !dis_exit) begin
            dis_cnt <= dis_cnt_now + DIS_W'(1);
        end
    end

    // Pending conf holds the latest write; it reaches the core only while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_conf <= '0;
            pend      <= 1'b1;
            core_conf <= '0;
        end else begin
            if (cfg_wr) begin
                pend_conf <= cfg_data;
            end
            if (conf_load) begin
                core_conf <= cfg_wr ? cfg_data : pend_conf;
                pend      <= 1'b0;
            end else if (cfg_wr) begin
                pend      <= 1'b1;
            end
        end
    end

    // Core enable drops when a disable period begins and rises when it ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_enable <= 1'b0;
        end else if (enter_dis) begin
            core_enable <= 1'b0;
        end else if (dis_exit) begin
            core_enable <= 1'b1;
        end
    end

    // Launch a sample: capture data and the current ack level, flip req.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_req     <= 1'b0;
            core_rx_data <= '0;
            ack_q        <= 1'b0;
        end else if (accept) begin
            core_req     <= ~core_req;
            core_rx_data <= in_data;
            ack_q        <= core_ack;
        end
    end

    // Ack watchdog: counts cycles spent in BUSY since the last accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if ((state == ST_BUSY) && !done && !timeout) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Single-entry result buffer; held until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (done) begin
            out_valid <= 1'b1;
            out_data  <= core_tx_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky timeout flag and saturating overflow count; a same-cycle event beats err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_err <= 1'b0;
            ovf_cnt <= '0;
        end else begin
            if (timeout) begin
                tmo_err <= 1'b1;
            end else if (err_clr) begin
                tmo_err <= 1'b0;
            end

            if (err_clr) begin
                ovf_cnt <= ovf_inc ? 8'd1 : 8'd0;
            end else if (ovf_inc && (ovf_cnt != 8'hFF)) begin
                ovf_cnt <= ovf_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_audio_ns_ctrl.sv
// Testbench for audio_ns_ctrl with a behavioural core stub and a result scoreboard.
module tb_audio_ns_ctrl;

    localparam int FIXWID  = 16;
    localparam int DIS_CYC = 20;
    localparam int TMO_CYC = 4096;
    localparam int CW      = 3*FIXWID+4;

    localparam logic [CW-1:0] CONF_A = {16'd1024, 16'd1024, 16'd0,  2'b00, 2'b00};
    localparam logic [CW-1:0] CONF_B = {16'd153,  16'd5427, 16'd10, 2'b10, 2'b10};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [FIXWID-1:0] in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic [FIXWID-1:0] out_data;
    logic              out_ready = 1'b1;
    logic              cfg_wr = 1'b0;
    logic [CW-1:0]     cfg_data = '0;
    logic              cfg_busy;
    logic [CW-1:0]     core_conf;
    logic              core_enable;
    logic              core_req;
    logic [FIXWID-1:0] core_rx_data;
    logic              core_ack = 1'b0;
    logic [FIXWID-1:0] core_tx_data = '0;
    logic              core_overflow = 1'b0;
    logic              tmo_err;
    logic [7:0]        ovf_cnt;
    logic              err_clr = 1'b0;

    audio_ns_ctrl #(
        .FIXWID  (FIXWID),
        .DIS_CYC (DIS_CYC),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .cfg_wr        (cfg_wr),
        .cfg_data      (cfg_data),
        .cfg_busy      (cfg_busy),
        .core_conf     (core_conf),
        .core_enable   (core_enable),
        .core_req      (core_req),
        .core_rx_data  (core_rx_data),
        .core_ack      (core_ack),
        .core_tx_data  (core_tx_data),
        .core_overflow (core_overflow),
        .tmo_err       (tmo_err),
        .ovf_cnt       (ovf_cnt),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [FIXWID-1:0] din;
        logic [FIXWID-1:0] dout;
    } vec_t;

    vec_t              vecs [8];
    logic [FIXWID-1:0] exp_q [$];
    int                checks_total  = 0;
    int                checks_passed = 0;
    int                bound_fails   = 0;
    int                req_toggles   = 0;
    int                results_seen  = 0;
    logic              prev_req      = 1'b0;

    // core stub controls and state
    logic              ack_on    = 1'b1;
    logic              ovf_force = 1'b0;
    logic              seen_req  = 1'b0;
    int                core_cnt  = 0;
    logic [FIXWID-1:0] core_rx_lat = '0;

    // Arithmetic stand-in for the noise-suppression core.
    function automatic logic [FIXWID-1:0] coreModel(input logic [FIXWID-1:0] rx,
                                                    input logic [CW-1:0] conf);
        return (rx ^ conf[35:20]) + conf[51:36] + conf[19:4] + FIXWID'(conf[3:0]);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic failBound(input string name);
        checks_total++;
        bound_fails++;
        $display("[TB] FAIL %s: wait expired, got no event, expected event", name);
    endtask

    // Core stub: echoes ack three cycles after seeing a req toggle, if enabled.
    always @(posedge clk) begin
        #1;
        if (core_req !== seen_req) begin
            seen_req    = core_req;
            core_rx_lat = core_rx_data;
            core_cnt    = 3;
        end else if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0 && ack_on && core_enable) begin
                core_tx_data  = coreModel(core_rx_lat, core_conf);
                core_overflow = ovf_force;
                core_ack      = ~core_ack;
            end
        end
    end

    // Monitor: counts req toggles and pops the scoreboard on each result handshake.
    always @(negedge clk) begin
        if (core_req !== prev_req) begin
            req_toggles++;
            prev_req = core_req;
        end
        if (!rst && out_valid && out_ready) begin
            results_seen++;
            if (exp_q.size() == 0) begin
                checks_total++;
                $display("[TB] FAIL unexpected_result: got 0x%0h, expected no result", out_data);
            end else begin
                checkOutput("out_data", 64'(out_data), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one sample until accepted; pushes its expected result if one is due.
    task automatic applyStimulus(input logic [FIXWID-1:0] din, input logic [FIXWID-1:0] dexp,
                                 input bit expect_result);
        bit taken = 1'b0;
        if (bound_fails > 3) return;
        in_valid = 1'b1;
        in_data  = din;
        for (int c = 0; c < 300 && !taken; c++) begin
            @(negedge clk);
            if (in_ready) begin
                taken = 1'b1;
                if (expect_result) exp_q.push_back(dexp);
            end
            tick();
        end
        in_valid = 1'b0;
        if (!taken) failBound("accept_wait");
    endtask

    task automatic applyCfg(input logic [CW-1:0] conf);
        cfg_wr   = 1'b1;
        cfg_data = conf;
        tick();
        cfg_wr   = 1'b0;
    endtask

    task automatic waitDrain();
        int c = 0;
        while ((exp_q.size() != 0 || out_valid) && c < 2000) begin
            tick();
            c++;
        end
        if (c >= 2000) failBound("drain_wait");
    endtask

    task automatic waitIdle();
        int c = 0;
        while (cfg_busy && c < 200) begin
            tick();
            c++;
        end
        if (c >= 200) failBound("idle_wait");
    endtask

    task automatic measureDisable(output int n);
        n = 0;
        while (!core_enable && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int               n;
        int               t0;
        int               r0;
        int               c;
        bit               flag;
        logic [FIXWID-1:0] d;
        logic             ack_before;

        vecs[0] = '{din: 16'h0000, dout: 16'h0800};
        vecs[1] = '{din: 16'h0001, dout: 16'h0801};
        vecs[2] = '{din: 16'h0400, dout: 16'h0400};
        vecs[3] = '{din: 16'hFFFF, dout: 16'hFFFF};
        vecs[4] = '{din: 16'h7FFF, dout: 16'h7FFF};
        vecs[5] = '{din: 16'h8000, dout: 16'h8800};
        vecs[6] = '{din: 16'h1234, dout: 16'h1A34};
        vecs[7] = '{din: 16'hFC00, dout: 16'hFC00};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_core_enable", 64'(core_enable), 64'(0));
        checkOutput("rst_core_req",    64'(core_req),    64'(0));
        checkOutput("rst_out_valid",   64'(out_valid),   64'(0));
        checkOutput("rst_in_ready",    64'(in_ready),    64'(0));
        checkOutput("rst_tmo_err",     64'(tmo_err),     64'(0));
        checkOutput("rst_ovf_cnt",     64'(ovf_cnt),     64'(0));
        checkOutput("rst_core_conf",   64'(core_conf),   64'(0));
        checkOutput("rst_cfg_busy",    64'(cfg_busy),    64'(1));
        rst = 1'b0;
        measureDisable(n);
        checkOutput("reset_disable_cycles", 64'(n), 64'(DIS_CYC));
        checkOutput("idle_in_ready",  64'(in_ready),  64'(1));
        checkOutput("idle_core_conf", 64'(core_conf), 64'(0));
        checkOutput("idle_cfg_busy",  64'(cfg_busy),  64'(0));

        // first conf and table vectors
        applyCfg(CONF_A);
        checkOutput("cfg_busy_after_write", 64'(cfg_busy), 64'(1));
        waitIdle();
        checkOutput("conf_a_applied", 64'(core_conf), 64'(CONF_A));
        for (int i = 0; i < 8; i++) applyStimulus(vecs[i].din, vecs[i].dout, 1'b1);
        waitDrain();

        // 500-sample stream
        t0 = req_toggles;
        r0 = results_seen;
        for (int i = 0; i < 500; i++) begin
            d = 16'($urandom);
            applyStimulus(d, coreModel(d, CONF_A), 1'b1);
        end
        waitDrain();
        checkOutput("stream_req_toggles", 64'(req_toggles - t0), 64'(500));
        checkOutput("stream_results",     64'(results_seen - r0), 64'(500));
        checkOutput("stream_ovf_cnt",     64'(ovf_cnt), 64'(0));

        // conf write while a sample is in flight
        applyStimulus(16'h1234, 16'h1A34, 1'b1);
        applyCfg(CONF_B);
        flag = 1'b0;
        c = 0;
        while (!out_valid && c < 100) begin
            if (!core_enable) flag = 1'b1;
            tick();
            c++;
        end
        if (c >= 100) failBound("midbusy_result_wait");
        checkOutput("midbusy_enable_held", 64'(flag || !core_enable), 64'(0));
        checkOutput("midbusy_cfg_busy", 64'(cfg_busy), 64'(1));
        c = 0;
        while (core_enable && c < 100) begin
            tick();
            c++;
        end
        if (c >= 100) failBound("midbusy_disable_wait");
        measureDisable(n);
        checkOutput("reconf_disable_cycles", 64'(n), 64'(DIS_CYC));
        checkOutput("conf_b_applied", 64'(core_conf), 64'(CONF_B));
        applyStimulus(16'h0000, 16'h15E0, 1'b1);
        applyStimulus(16'h1533, 16'h00AD, 1'b1);
        waitDrain();

        // ack timeout
        ack_on = 1'b0;
        applyStimulus(16'h0055, 16'h0000, 1'b0);
        repeat (TMO_CYC - 1) @(posedge clk);
        #1;
        checkOutput("tmo_before_limit",    64'(tmo_err),     64'(0));
        checkOutput("tmo_enable_before",   64'(core_enable), 64'(1));
        tick();
        checkOutput("tmo_at_limit",        64'(tmo_err),     64'(1));
        checkOutput("tmo_enable_dropped",  64'(core_enable), 64'(0));
        checkOutput("tmo_cfg_busy",        64'(cfg_busy),    64'(1));
        checkOutput("tmo_no_out_valid",    64'(out_valid),   64'(0));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("tmo_err_cleared", 64'(tmo_err), 64'(0));
        ack_on = 1'b1;
        waitIdle();
        checkOutput("tmo_conf_kept", 64'(core_conf), 64'(CONF_B));
        applyStimulus(16'h1533, 16'h00AD, 1'b1);
        waitDrain();

        // output backpressure
        out_ready = 1'b0;
        applyStimulus(16'h0000, 16'h15E0, 1'b1);
        c = 0;
        while (!out_valid && c < 100) begin
            tick();
            c++;
        end
        if (c >= 100) failBound("bp_result_wait");
        t0 = req_toggles;
        flag = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h4321;
        repeat (100) begin
            tick();
            if (in_ready) flag = 1'b1;
        end
        checkOutput("bp_in_ready_low", 64'(flag),                64'(0));
        checkOutput("bp_out_valid",    64'(out_valid),           64'(1));
        checkOutput("bp_out_data",     64'(out_data),            64'(16'h15E0));
        checkOutput("bp_no_req",       64'(req_toggles - t0),    64'(0));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        applyStimulus(16'h4321, coreModel(16'h4321, CONF_B), 1'b1);
        waitDrain();

        // overflow saturation
        ovf_force = 1'b1;
        for (int i = 0; i < 300; i++) begin
            d = 16'($urandom);
            applyStimulus(d, coreModel(d, CONF_B), 1'b1);
        end
        waitDrain();
        checkOutput("ovf_saturated", 64'(ovf_cnt), 64'(255));

        // err_clr on the same edge as an overflow result
        applyStimulus(16'h0101, coreModel(16'h0101, CONF_B), 1'b1);
        ack_before = core_ack;
        c = 0;
        while (core_ack === ack_before && c < 50) begin
            @(posedge clk);
            #2;
            c++;
        end
        if (c >= 50) failBound("ovf_ack_wait");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("ovf_clr_same_cycle", 64'(ovf_cnt),   64'(1));
        checkOutput("ovf_clr_result",     64'(out_valid), 64'(1));
        ovf_force = 1'b0;
        waitDrain();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("ovf_cleared", 64'(ovf_cnt), 64'(0));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
